// File: rtl/npc_ras_if.sv
// npc_ras_if: control/datapath bundle between the CPU and the next-PC/RAS unit
interface npc_ras_if #(
  parameter int AW = 32,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  logic pc_we;
  logic validbr;
  logic [2:0] jump;
  logic [25:0] imminstr;
  logic [31:0] aluresult;
  logic [AW-3:0] pc;
  logic [AW-3:0] npc;
  logic [AW-3:0] pcfour;
  logic [AW-3:0] ras_top;
  logic [CW-1:0] ras_count;
  logic ras_empty;
  logic ras_full;
  logic ras_hit;
  logic ras_miss;
  logic ras_ovf;
  modport master (
    output pc_we, validbr, jump, imminstr, aluresult,
    input pc, npc, pcfour, ras_top, ras_count, ras_empty, ras_full, ras_hit, ras_miss, ras_ovf
  );
  modport slave (
    input pc_we, validbr, jump, imminstr, aluresult,
    output pc, npc, pcfour, ras_top, ras_count, ras_empty, ras_full, ras_hit, ras_miss, ras_ovf
  );
endinterface

// File: rtl/npc_ras.sv
// npc_ras: PC register, next-PC selection and circular return-address stack
module npc_ras #(
  parameter int AW = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter int RAS_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  npc_ras_if.slave bus
);
  localparam int W = AW - 2;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [W-1:0] RST_PC = RESET_VEC[AW-1:2];
  localparam logic [2:0] J = 3'd1;
  localparam logic [2:0] JAL = 3'd2;
  localparam logic [2:0] JR = 3'd3;
  localparam logic [2:0] JALR = 3'd4;
  logic [W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nx;
  logic [CW-1:0] count;
  logic [W-1:0] pc;
  logic [W-1:0] pcfour;
  logic [W-1:0] pc1;
  logic [W-1:0] jt;
  logic [W-1:0] npc;
  logic [W-1:0] top;
  logic [W-1:0] target;
  logic full;
  logic push;
  logic pop;
  logic hit;
  logic miss;
  logic ovf;
  assign pc1 = pc + 1'b1;
  assign ptr_nx = ptr + 1'b1;
  assign target = bus.aluresult[AW-1:2];
  assign full = count == CW'(RAS_DEPTH);
  assign top = count == '0 ? '0 : stack[ptr];
  assign push = bus.pc_we && !bus.validbr && (bus.jump == JAL || bus.jump == JALR);
  assign pop = bus.pc_we && !bus.validbr && bus.jump == JR;
  // J/JAL keep the PC's upper region and replace the low 26 word-address bits
  always_comb begin
    jt = pc;
    jt[25:0] = bus.imminstr;
  end
  // next-PC selection: branch beats jumps, undefined jump codes fall through to pc+1
  always_comb begin
    npc = bus.validbr ? pc + {{(W-16){bus.imminstr[15]}}, bus.imminstr[15:0]}
        : (bus.jump == J || bus.jump == JAL) ? jt
        : (bus.jump == JR || bus.jump == JALR) ? target
        : pc1;
  end
  // PC, link value, stack pointer/count and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RST_PC;
      pcfour <= RST_PC + 1'b1;
      ptr <= '0;
      count <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      ovf <= 1'b0;
    end else begin
      hit <= 1'b0;
      miss <= 1'b0;
      ovf <= 1'b0;
      if (bus.pc_we) begin
        pc <= npc;
        pcfour <= pc1;
      end
      if (push) begin
        ptr <= ptr_nx;
        count <= full ? count : count + 1'b1;
        ovf <= full;
      end
      if (pop) begin
        if (count != '0) begin
          ptr <= ptr - 1'b1;
          count <= count - 1'b1;
          hit <= top == target;
          miss <= top != target;
        end else begin
          miss <= 1'b1;
        end
      end
    end
  end
  // stack storage; a push while full lands on the oldest slot since ptr+1 wraps onto it
  always_ff @(posedge clk) begin
    if (push) stack[ptr_nx] <= pc1;
  end
  assign bus.pc = pc;
  assign bus.npc = npc;
  assign bus.pcfour = pcfour;
  assign bus.ras_top = top;
  assign bus.ras_count = count;
  assign bus.ras_empty = count == '0;
  assign bus.ras_full = full;
  assign bus.ras_hit = hit;
  assign bus.ras_miss = miss;
  assign bus.ras_ovf = ovf;
endmodule

// File: tb/tb_npc_ras.sv
// tb_npc_ras: directed checks of next-PC selection, PC/link registers and the RAS
module tb_npc_ras;
  localparam logic [2:0] NJ = 3'd0;
  localparam logic [2:0] J = 3'd1;
  localparam logic [2:0] JAL = 3'd2;
  localparam logic [2:0] JR = 3'd3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  npc_ras_if #(.AW(32), .RAS_DEPTH(8)) bus ();
  npc_ras #(.AW(32), .RESET_VEC(32'h0000_3000), .RAS_DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
  endtask
  task automatic exec(input string tag, input logic [2:0] j, input logic vb, input logic [25:0] imm,
                      input logic [31:0] alu, input logic [31:0] exp_pc);
    bus.jump = j;
    bus.validbr = vb;
    bus.imminstr = imm;
    bus.aluresult = alu;
    #1;
    chk({tag, ".npc"}, 32'(bus.npc), exp_pc);
    bus.pc_we = 1'b1;
    @(posedge clk);
    #1;
    bus.pc_we = 1'b0;
    chk({tag, ".pc"}, 32'(bus.pc), exp_pc);
  endtask
  initial begin
    logic [31:0] p;
    logic [31:0] e;
    bus.pc_we = 1'b0;
    bus.validbr = 1'b0;
    bus.jump = NJ;
    bus.imminstr = '0;
    bus.aluresult = '0;
    #3 rst = 1'b1;
    #1;
    chk("rst.pc", 32'(bus.pc), 32'hC00);
    chk("rst.pcfour", 32'(bus.pcfour), 32'hC01);
    chk("rst.count", 32'(bus.ras_count), 0);
    chk("rst.top", 32'(bus.ras_top), 0);
    chk("rst.empty", 32'(bus.ras_empty), 1);
    chk("rst.pulses", {29'd0, bus.ras_hit, bus.ras_miss, bus.ras_ovf}, 0);
    #8 rst = 1'b0;
    exec("seq1", NJ, 1'b0, 26'd0, 32'd0, 32'hC01);
    chk("seq1.pcfour", 32'(bus.pcfour), 32'hC01);
    exec("seq2", NJ, 1'b0, 26'd0, 32'd0, 32'hC02);
    exec("seq3", NJ, 1'b0, 26'd0, 32'd0, 32'hC03);
    chk("seq3.pcfour", 32'(bus.pcfour), 32'hC03);
    exec("j_c10", J, 1'b0, 26'hC10, 32'd0, 32'hC10);
    exec("br", J, 1'b1, 26'h000FFFC, 32'd0, 32'hC0C);
    chk("br.count", 32'(bus.ras_count), 0);
    chk("br.pcfour", 32'(bus.pcfour), 32'hC11);
    exec("j_c20", J, 1'b0, 26'hC20, 32'd0, 32'hC20);
    exec("jal", JAL, 1'b0, 26'h0000400, 32'd0, 32'h400);
    chk("jal.top", 32'(bus.ras_top), 32'hC21);
    chk("jal.count", 32'(bus.ras_count), 1);
    chk("jal.pcfour", 32'(bus.pcfour), 32'hC21);
    exec("jr_hit", JR, 1'b0, 26'd0, 32'h3084, 32'hC21);
    chk("jr_hit.hit", 32'(bus.ras_hit), 1);
    chk("jr_hit.miss", 32'(bus.ras_miss), 0);
    chk("jr_hit.empty", 32'(bus.ras_empty), 1);
    idle();
    chk("jr_hit.clear", 32'(bus.ras_hit), 0);
    exec("j_c20b", J, 1'b0, 26'hC20, 32'd0, 32'hC20);
    exec("jal2", JAL, 1'b0, 26'h0000400, 32'd0, 32'h400);
    chk("jal2.top", 32'(bus.ras_top), 32'hC21);
    exec("jr_miss", JR, 1'b0, 26'd0, 32'h5000, 32'h1400);
    chk("jr_miss.miss", 32'(bus.ras_miss), 1);
    chk("jr_miss.hit", 32'(bus.ras_hit), 0);
    chk("jr_miss.count", 32'(bus.ras_count), 0);
    idle();
    chk("jr_miss.clear", 32'(bus.ras_miss), 0);
    exec("jr_empty", JR, 1'b0, 26'd0, 32'h5000, 32'h1400);
    chk("jr_empty.miss", 32'(bus.ras_miss), 1);
    chk("jr_empty.count", 32'(bus.ras_count), 0);
    chk("jr_empty.top", 32'(bus.ras_top), 0);
    for (int i = 0; i < 9; i++) begin
      p = 32'(bus.pc);
      exec("ovf_jal", JAL, 1'b0, 26'(32'h100 * (i + 1)), 32'd0, 32'h100 * (i + 1));
      chk("ovf_jal.ovf", 32'(bus.ras_ovf), (i == 8) ? 1 : 0);
      chk("ovf_jal.count", 32'(bus.ras_count), (i < 8) ? i + 1 : 8);
      chk("ovf_jal.top", 32'(bus.ras_top), p + 1);
    end
    chk("ovf.full", 32'(bus.ras_full), 1);
    for (int k = 0; k < 8; k++) begin
      e = 32'h100 * (8 - k) + 1;
      chk("pop.top", 32'(bus.ras_top), e);
      exec("pop", JR, 1'b0, 26'd0, e << 2, e);
      chk("pop.hit", 32'(bus.ras_hit), 1);
      chk("pop.count", 32'(bus.ras_count), 7 - k);
    end
    chk("pop.empty", 32'(bus.ras_empty), 1);
    exec("lost", JR, 1'b0, 26'd0, 32'h1401 << 2, 32'h1401);
    chk("lost.miss", 32'(bus.ras_miss), 1);
    bus.jump = JAL;
    bus.imminstr = 26'h123;
    repeat (5) idle();
    chk("hold.pc", 32'(bus.pc), 32'h1401);
    chk("hold.pcfour", 32'(bus.pcfour), 32'h102);
    chk("hold.count", 32'(bus.ras_count), 0);
    chk("hold.pulses", {29'd0, bus.ras_hit, bus.ras_miss, bus.ras_ovf}, 0);
    exec("jrmax", JR, 1'b0, 26'd0, 32'hFFFF_FFFF, 32'h3FFF_FFFF);
    exec("wrap", NJ, 1'b0, 26'd0, 32'd0, 32'h0);
    chk("wrap.pcfour", 32'(bus.pcfour), 0);
    exec("code5", 3'd5, 1'b0, 26'h3FF_FFFF, 32'h1234, 32'h1);
    exec("jal3", JAL, 1'b0, 26'h0000800, 32'd0, 32'h800);
    bus.jump = JAL;
    bus.pc_we = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst2.pc", 32'(bus.pc), 32'hC00);
    chk("rst2.count", 32'(bus.ras_count), 0);
    idle();
    chk("rst2.hold", 32'(bus.pc), 32'hC00);
    bus.pc_we = 1'b0;
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
